// File: rtl/seq_gen_pkg.sv
// seq_gen shared types and helpers.
// Bit-serial pattern transmitter package.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic IDLE_LVL_DEF = 1'b0;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_gen_piso.sv
// seq_gen parallel-load MSB-first shift register.
// Pattern is left-aligned at load so the head bit is always the register MSB.
module seq_gen_piso
  import seq_gen_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  localparam int LEN_W   = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               sbit,
  output logic               last
);

  logic [MAX_LEN-1:0] sr;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   sh_amt;

  assign sh_amt = LEN_W'(MAX_LEN) - len;
  assign sbit   = sr[MAX_LEN-1];
  assign last   = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      unique case (1'b1)
        load: begin
          sr  <= pattern << sh_amt;
          cnt <= len - LEN_W'(1);
        end
        shift: begin
          sr  <= {sr[MAX_LEN-2:0], 1'b0};
          cnt <= cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/seq_gen.sv
// seq_gen top: FSM, repeat and gap counters.
// Drives a bit-serial pattern with repeats and idle gaps.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter  int   MAX_LEN  = 16,
  parameter  int   CNT_W    = 8,
  parameter  logic IDLE_LVL = IDLE_LVL_DEF,
  localparam int   LEN_W    = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [CNT_W-1:0]   reps,
  input  logic [CNT_W-1:0]   gap,
  input  logic               abort,
  output logic               dout,
  output logic               dout_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   gap_q;
  logic [CNT_W-1:0]   rep_cnt;
  logic [CNT_W-1:0]   gap_cnt;
  logic               cont;

  logic               legal;
  logic               accept;
  logic               finish;
  logic               load;
  logic               shift;
  logic               sbit;
  logic               last;
  logic [MAX_LEN-1:0] p_pat;
  logic [LEN_W-1:0]   p_len;

  assign legal  = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign accept = (state == IDLE) && start && !abort && legal;
  assign finish = !cont && (rep_cnt == CNT_W'(1));

  // First load comes straight from the ports; repeats reuse the capture.
  assign p_pat = (state == IDLE) ? pattern : pat_q;
  assign p_len = (state == IDLE) ? len : len_q;

  always_comb begin
    load  = 1'b0;
    shift = 1'b0;
    if (accept)
      load = 1'b1;
    if (state == SEND && !abort) begin
      if (!last)
        shift = 1'b1;
      else if (!finish && gap_q == '0)
        load = 1'b1;
    end
    if (state == GAP && !abort && gap_cnt == CNT_W'(1))
      load = 1'b1;
  end

  seq_gen_piso #(
    .MAX_LEN(MAX_LEN)
  ) u_piso (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .shift  (shift),
    .pattern(p_pat),
    .len    (p_len),
    .sbit   (sbit),
    .last   (last)
  );

  assign dout = dout_valid ? sbit : IDLE_LVL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      pat_q      <= '0;
      len_q      <= '0;
      gap_q      <= '0;
      rep_cnt    <= '0;
      gap_cnt    <= '0;
      cont       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            if (legal) begin
              state      <= SEND;
              dout_valid <= 1'b1;
              busy       <= 1'b1;
              pat_q      <= pattern;
              len_q      <= len;
              gap_q      <= gap;
              rep_cnt    <= reps;
              cont       <= (reps == '0);
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEND: begin
          if (abort) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
          end else if (last) begin
            if (finish) begin
              state      <= IDLE;
              dout_valid <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              rep_cnt    <= '0;
            end else begin
              if (!cont)
                rep_cnt <= rep_cnt - CNT_W'(1);
              if (gap_q != '0) begin
                state      <= GAP;
                dout_valid <= 1'b0;
                gap_cnt    <= gap_q;
              end
            end
          end
        end
        GAP: begin
          if (abort) begin
            state      <= IDLE;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            gap_cnt    <= '0;
          end else if (gap_cnt == CNT_W'(1)) begin
            state      <= SEND;
            dout_valid <= 1'b1;
            gap_cnt    <= '0;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// seq_gen bench: directed and random frames against a queue model.
// Expected streams are built from pattern/len/reps/gap directly.
module tb_seq_gen;

  localparam int   MAX_LEN  = 16;
  localparam int   CNT_W    = 8;
  localparam logic IDLE_LVL = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [7:0]  reps;
  logic [7:0]  gap;
  logic        dout;
  logic        dout_valid;
  logic        busy;
  logic        done;
  logic        err;

  int n_assert = 0;
  int n_fail   = 0;

  seq_gen #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W),
    .IDLE_LVL(IDLE_LVL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .gap       (gap),
    .abort     (abort),
    .dout      (dout),
    .dout_valid(dout_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_dout"}, dout, IDLE_LVL);
  endtask

  // Ends in the done cycle; caller decides what happens next.
  task automatic run_frame(input logic [15:0] p, input int l, input int r,
                           input int g, input int disturb);
    logic [1:0] q[$];
    for (int k = 0; k < r; k++) begin
      for (int b = l - 1; b >= 0; b--)
        q.push_back({1'b1, p[b]});
      if (k < r - 1)
        for (int j = 0; j < g; j++)
          q.push_back({1'b0, IDLE_LVL});
    end
    pattern = p;
    len     = l[4:0];
    reps    = r[7:0];
    gap     = g[7:0];
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      chk("frm_valid", dout_valid, q[i][1]);
      chk("frm_dout", dout, q[i][0]);
      chk("frm_busy", busy, 1);
      chk("frm_done", done, 0);
      if (i == disturb) begin
        pattern = ~p;
        len     = 5'($urandom_range(1, 16));
        reps    = 8'($urandom);
        gap     = 8'($urandom);
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("frm_done_pulse", done, 1);
    chk("frm_done_err", err, 0);
    chk_idle("frm_end");
  endtask

  initial begin
    logic [15:0] p;
    int          l;
    int          r;
    int          g;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    len     = '0;
    reps    = '0;
    gap     = '0;
    #12;
    chk_idle("rst");
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Single short frame, then two reps with a gap.
    run_frame(16'h0005, 3, 1, 0, -1);
    tick();
    chk("t1_done_clr", done, 0);
    run_frame(16'h0005, 3, 2, 2, -1);
    tick();
    chk("t2_done_clr", done, 0);

    // Illegal lengths.
    for (int k = 0; k < 2; k++) begin
      len   = (k == 0) ? 5'd0 : 5'd17;
      reps  = 8'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("bad_err", err, 1);
      chk("bad_done", done, 0);
      chk_idle("bad");
      tick();
      chk("bad_err_clr", err, 0);
      chk_idle("bad2");
    end

    // Continuous A5A5, then abort.
    p       = 16'hA5A5;
    pattern = p;
    len     = 5'd16;
    reps    = 8'd0;
    gap     = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      chk("cont_valid", dout_valid, 1);
      chk("cont_dout", dout, p[15 - (i % 16)]);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort");
    chk("abort_done", done, 0);
    tick();
    chk("abort_done2", done, 0);
    chk_idle("abort2");

    // Inputs changed and start pulsed mid-frame.
    run_frame(16'($urandom), 5, 3, 1, 4);
    tick();

    // Asynchronous reset mid-frame.
    pattern = 16'hFFFF;
    len     = 5'd8;
    reps    = 8'd2;
    gap     = 8'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_valid", dout_valid, 1);
    chk("pre_rst_dout", dout, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_done", done, 0);
    #1 rst_n = 1'b1;
    tick();
    chk_idle("arst2");
    chk("arst2_done", done, 0);

    // Start in the done cycle, then boundary lengths.
    run_frame(16'h0006, 3, 1, 0, -1);
    run_frame(16'h0009, 4, 2, 0, -1);
    tick();
    run_frame(16'h0001, 1, 3, 0, -1);
    tick();
    run_frame(16'h8001, 16, 2, 1, -1);
    tick();

    // abort together with start in IDLE.
    for (int k = 0; k < 2; k++) begin
      pattern = 16'h000F;
      len     = (k == 0) ? 5'd4 : 5'd0;
      reps    = 8'd1;
      start   = 1'b1;
      abort   = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk("abst_err", err, 0);
      chk_idle("abst");
    end

    // Random frames.
    for (int n = 0; n < 10; n++) begin
      p = 16'($urandom);
      l = $urandom_range(1, 16);
      r = $urandom_range(1, 3);
      g = $urandom_range(0, 3);
      run_frame(p, l, r, g, (n % 2 == 0) ? -1 : int'($urandom_range(0, l - 1)));
      if (n % 3 != 0) begin
        tick();
        chk("rnd_done_clr", done, 0);
      end
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
